// File: rtl/booth_pkg.sv
// Shared types and constants for the booth_mult issue/collect controller.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERROR = 2'd3
  } issue_state_t;

  localparam int BOOTH_W_DEFAULT = 8;

  // Cycles from the ISSUE cycle's start edge through the finish-sampling cycle.
  function automatic int booth_latency(input int w);
    return 2 * w + 3;
  endfunction

endpackage

// File: rtl/op_fifo.sv
// Synchronous operand FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module op_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/booth_issue_ctrl.sv
// Buffers signed operand pairs, issues them to booth_mult one at a time, bypasses
// zero operands, collects results into a one-entry output register and watches for hangs.
module booth_issue_ctrl
  import booth_pkg::*;
#(
  parameter int W     = BOOTH_W_DEFAULT,
  parameter int DEPTH = 2,
  parameter int TMO   = 2 * W + 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_product,
  output logic           err,
  output logic           mult_start,
  output logic [W-1:0]   mult_a,
  output logic [W-1:0]   mult_b,
  input  logic [2*W-1:0] mult_product,
  input  logic           mult_finish,
  output issue_state_t   dbg_state
);

  localparam int WDW = $clog2(TMO + 1);

  issue_state_t   state_q, state_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           out_valid_q;
  logic [2*W-1:0] out_product_q;
  logic [W-1:0]   mult_a_q, mult_b_q;

  logic [2*W-1:0] head;
  logic           fifo_full, fifo_empty;
  logic           push, pop;
  logic           head_zero, out_free;
  logic           load;
  logic [2*W-1:0] load_val;
  logic           issue_load;

  // Both streams transfer on a rising edge where valid && ready; valid may not
  // depend on ready, and a source holds its data stable until the transfer.
  assign push      = in_valid && in_ready;
  assign in_ready  = reset_n && (state_q != ST_ERROR) && (!fifo_full || pop);
  assign head_zero = (head[2*W-1:W] == '0) || (head[W-1:0] == '0);
  assign out_free  = !out_valid_q || out_ready;

  op_fifo #(
    .WIDTH (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .data_i  ({in_a, in_b}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    pop        = 1'b0;
    load       = 1'b0;
    load_val   = '0;
    issue_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head_zero) begin
            if (out_free) begin
              pop  = 1'b1;
              load = 1'b1;
            end
          end else begin
            pop        = 1'b1;
            issue_load = 1'b1;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A finished result waiting on a full output register is not a hang.
        if (mult_finish) begin
          if (out_free) begin
            load     = 1'b1;
            load_val = mult_product;
            state_d  = ST_IDLE;
          end
        end else if (wd_q == WDW'(TMO - 1)) begin
          state_d = ST_ERROR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wd_q          <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if (load) begin
        out_valid_q   <= 1'b1;
        out_product_q <= load_val;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (issue_load) begin
        mult_a_q <= head[2*W-1:W];
        mult_b_q <= head[W-1:0];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign mult_start  = (state_q == ST_ISSUE);
  assign err         = (state_q == ST_ERROR);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Bench for booth_issue_ctrl with a behavioural booth_mult stand-in attached.
module tb_booth_issue_ctrl;
  import booth_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 2;
  localparam int TMO   = 2 * W + 4;
  localparam int LAT   = booth_latency(W) + 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid, in_ready;
  logic [W-1:0]   in_a, in_b;
  logic           out_valid, out_ready;
  logic [2*W-1:0] out_product;
  logic           err, mult_start;
  logic [W-1:0]   mult_a, mult_b;
  logic [2*W-1:0] mult_product;
  logic           mult_finish;
  issue_state_t   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];

  booth_issue_ctrl #(.W(W), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .err          (err),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_product (mult_product),
    .mult_finish  (mult_finish),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / global time limit ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // ---------------- reference arithmetic ----------------
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  // ---------------- booth_mult stand-in: finish 2W cycles after the start edge ----------------
  logic           mdl_busy, mdl_fin_q, hang;
  int             mdl_cnt;
  logic [2*W-1:0] mdl_prod;
  logic [W-1:0]   mdl_a, mdl_b;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_busy  <= 1'b0;
      mdl_cnt   <= 0;
      mdl_fin_q <= 1'b1;
      mdl_prod  <= 16'hDEAD;
      mdl_a     <= '0;
      mdl_b     <= '0;
    end else if (mult_start) begin
      mdl_busy  <= 1'b1;
      mdl_cnt   <= 1;
      mdl_fin_q <= 1'b0;
      mdl_a     <= mult_a;
      mdl_b     <= mult_b;
    end else if (mdl_busy) begin
      if (mdl_cnt == 2 * W) begin
        mdl_fin_q <= 1'b1;
        mdl_busy  <= 1'b0;
        mdl_prod  <= ref_prod(mdl_a, mdl_b);
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  assign mult_finish  = mdl_fin_q && !hang;
  assign mult_product = mdl_prod;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every output handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got %0h expected no result at %0t", out_product, $time);
      end else begin
        check("out_product", {16'h0, out_product}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},    {31'h0, in_ready}, 32'h0);
    check({tag, "_out_valid"},   {31'h0, out_valid}, 32'h0);
    check({tag, "_out_product"}, {16'h0, out_product}, 32'h0);
    check({tag, "_err"},         {31'h0, err}, 32'h0);
    check({tag, "_mult_start"},  {31'h0, mult_start}, 32'h0);
    check({tag, "_mult_a"},      {24'h0, mult_a}, 32'h0);
    check({tag, "_mult_b"},      {24'h0, mult_b}, 32'h0);
    check({tag, "_state"},       {30'h0, dbg_state}, {30'h0, ST_IDLE});
  endtask

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b, input bit exp_en);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("push_accept", 32'h0, 32'h1);
    else if (exp_en) exp_q.push_back(ref_prod(a, b));
  endtask

  task automatic wait_drain(input int maxc, input string name);
    for (int i = 0; i < maxc && (exp_q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check(name, exp_q.size(), 32'h0);
  endtask

  // Push one pair into an idle controller and measure output latency and start pulses.
  task automatic timed_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] p, input int exp_lat, input int exp_starts);
    int cyc, first, starts;
    logic [W-1:0] ma, mb;
    exp_q.push_back(p);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    check("accept", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1; first = 0; starts = 0; ma = '0; mb = '0;
    while (first == 0 && cyc <= 60) begin
      @(negedge clk);
      if (mult_start) begin
        starts++;
        ma = mult_a;
        mb = mult_b;
      end
      if (out_valid) first = cyc;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", first, exp_lat);
    check("start_pulses", starts, exp_starts);
    if (exp_starts != 0) begin
      check("mult_a", {24'h0, ma}, {24'h0, a});
      check("mult_b", {24'h0, mb}, {24'h0, b});
    end
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    int             lat;
    int             starts;
  } vec_t;

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl[6];
    int cyc, first_err;
    logic ir_at_err;
    bit rand_done;

    tbl[0] = '{a: 8'hFD, b: 8'h05, p: 16'hFFF1, lat: LAT, starts: 1};
    tbl[1] = '{a: 8'h00, b: 8'h7F, p: 16'h0000, lat: 2,   starts: 0};
    tbl[2] = '{a: 8'h7F, b: 8'h80, p: 16'hC080, lat: LAT, starts: 1};
    tbl[3] = '{a: 8'h80, b: 8'h80, p: 16'h4000, lat: LAT, starts: 1};
    tbl[4] = '{a: 8'h05, b: 8'h00, p: 16'h0000, lat: 2,   starts: 0};
    tbl[5] = '{a: 8'hFF, b: 8'h01, p: 16'hFFFF, lat: LAT, starts: 1};

    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; hang = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'h0, in_ready}, 32'h1);

    // Isolated pairs: latency, start pulse count and issued operands.
    for (int i = 0; i < 6; i++) timed_pair(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].lat, tbl[i].starts);
    wait_drain(50, "table_drain");

    // Back-to-back pushes fill the two-entry FIFO.
    push_pair(8'h7F, 8'h7F, 1'b1);
    push_pair(8'h80, 8'h80, 1'b1);
    push_pair(8'hFF, 8'h01, 1'b1);
    @(negedge clk);
    check("ready_when_full", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    wait_drain(150, "b2b_drain");

    // Output held across two completions; second result replaces first without a bubble.
    out_ready = 1'b0;
    push_pair(8'h7F, 8'h7F, 1'b1);
    push_pair(8'h81, 8'h03, 1'b1);
    repeat (43) @(posedge clk);
    #1;
    @(negedge clk);
    check("hold_valid",   {31'h0, out_valid}, 32'h1);
    check("hold_product", {16'h0, out_product}, 32'h3F01);
    check("hold_state",   {30'h0, dbg_state}, {30'h0, ST_WAIT});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("next_valid",   {31'h0, out_valid}, 32'h1);
    check("next_product", {16'h0, out_product}, 32'hFE83);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain(20, "hold_drain");

    // Watchdog: zero result parked in the output, then a hung multiply.
    out_ready = 1'b0;
    hang = 1'b1;
    push_pair(8'h00, 8'h05, 1'b1);
    push_pair(8'h03, 8'h03, 1'b0);
    cyc = 2; first_err = 0; ir_at_err = 1'b1;
    while (cyc <= 32) begin
      @(negedge clk);
      if (err && first_err == 0) begin
        first_err = cyc;
        ir_at_err = in_ready;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("err_cycle", first_err, 4 + TMO);
    check("err_in_ready", {31'h0, ir_at_err}, 32'h0);
    check("err_parked_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    wait_drain(10, "err_drain");
    repeat (10) @(posedge clk);
    #1;
    check("err_sticky", {31'h0, err}, 32'h1);
    check("err_ready_low", {31'h0, in_ready}, 32'h0);
    hang = 1'b0;

    // Reset in the middle of WAIT with a zero pair still queued.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    push_pair(8'h11, 8'h22, 1'b1);
    push_pair(8'h00, 8'h00, 1'b1);
    repeat (6) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    timed_pair(8'hFD, 8'h05, 16'hFFF1, LAT, 1);
    repeat (40) @(posedge clk);
    #1;
    check("post_reset_idle", {31'h0, out_valid}, 32'h0);

    // Randomized traffic with random output backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [W-1:0] a, b;
          int r;
          a = W'($urandom);
          b = W'($urandom);
          r = $urandom_range(0, 9);
          if (r == 0 || r == 2) a = '0;
          if (r == 1 || r == 2) b = '0;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          push_pair(a, b, 1'b1);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(400, "random_drain");
    check("random_no_err", {31'h0, err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
